vga_timing_gen: RTL and testbench



---
 rtl/vga_timing_gen.sv | 152 +++++++++++++++
 tb/tb_vga_timing_gen.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator: pixel/line/frame counters, programmable-polarity
// syncs, display-active flag and strobes, with a pix_en-gated delay pipeline on the sync outputs.
module vga_timing_gen #(
   parameter int H_ACTIVE   = 640,
   parameter int H_FP       = 16,
   parameter int H_SYNC     = 96,
   parameter int H_BP       = 48,
   parameter int V_ACTIVE   = 480,
   parameter int V_FP       = 10,
   parameter int V_SYNC     = 2,
   parameter int V_BP       = 33,
   parameter int H_SYNC_POL = 0,
   parameter int V_SYNC_POL = 0,
   parameter int COUNT_W    = 11,
   parameter int FRAME_W    = 8,
   parameter int SYNC_DELAY = 2
) (
   input  logic               vga_clock,
   input  logic               reset_n,
   input  logic               pix_en,
   output logic [COUNT_W-1:0] hcount,
   output logic [COUNT_W-1:0] vcount,
   output logic               hsync,
   output logic               vsync,
   output logic               at_display_area,
   output logic               blank,
   output logic               start_of_frame,
   output logic               end_of_line,
   output logic [FRAME_W-1:0] frame_count
);

   localparam int H_TOTAL   = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL   = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int MAX_TOTAL = (H_TOTAL > V_TOTAL) ? H_TOTAL : V_TOTAL;

   if (((MAX_TOTAL - 1) >> COUNT_W) != 0) begin : g_bad_count_w
      $error("vga_timing_gen: COUNT_W too narrow for H_TOTAL/V_TOTAL");
   end
   if (SYNC_DELAY < 0 || SYNC_DELAY > 7) begin : g_bad_sync_delay
      $error("vga_timing_gen: SYNC_DELAY must be 0..7");
   end

   localparam logic [COUNT_W-1:0] H_LAST     = COUNT_W'(H_TOTAL - 1);
   localparam logic [COUNT_W-1:0] V_LAST     = COUNT_W'(V_TOTAL - 1);
   localparam logic [COUNT_W-1:0] H_ACT      = COUNT_W'(H_ACTIVE);
   localparam logic [COUNT_W-1:0] V_ACT      = COUNT_W'(V_ACTIVE);
   localparam logic [COUNT_W-1:0] H_ACT_LAST = COUNT_W'(H_ACTIVE - 1);
   localparam logic [COUNT_W-1:0] HS_START   = COUNT_W'(H_ACTIVE + H_FP);
   localparam logic [COUNT_W-1:0] HS_END     = COUNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
   localparam logic [COUNT_W-1:0] VS_START   = COUNT_W'(V_ACTIVE + V_FP);
   localparam logic [COUNT_W-1:0] VS_END     = COUNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);
   localparam logic               HS_ON      = (H_SYNC_POL != 0);
   localparam logic               VS_ON      = (V_SYNC_POL != 0);

   typedef struct packed {
      logic hsync;
      logic vsync;
      logic active;
   } vid_t;

   localparam vid_t VID_IDLE = vid_t'{hsync: ~HS_ON, vsync: ~VS_ON, active: 1'b0};

   logic [COUNT_W-1:0] hcount_q, hcount_d;
   logic [COUNT_W-1:0] vcount_q, vcount_d;
   logic [FRAME_W-1:0] frame_count_q, frame_count_d;
   logic               h_wrap, v_wrap;
   vid_t               vid_raw, vid_out;

   assign h_wrap = (hcount_q == H_LAST);
   assign v_wrap = (vcount_q == V_LAST);

   // NOTE: every variable assigned in always_comb gets a default first, so no path can infer a latch.
   always_comb begin
      hcount_d      = hcount_q;
      vcount_d      = vcount_q;
      frame_count_d = frame_count_q;
      if (pix_en) begin
         if (h_wrap) begin
            hcount_d = '0;
            if (v_wrap) begin
               vcount_d      = '0;
               frame_count_d = frame_count_q + FRAME_W'(1);
            end else begin
               vcount_d = vcount_q + COUNT_W'(1);
            end
         end else begin
            hcount_d = hcount_q + COUNT_W'(1);
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
   always_ff @(posedge vga_clock or negedge reset_n) begin
      if (!reset_n) begin
         hcount_q      <= '0;
         vcount_q      <= '0;
         frame_count_q <= '0;
      end else begin
         hcount_q      <= hcount_d;
         vcount_q      <= vcount_d;
         frame_count_q <= frame_count_d;
      end
   end

   always_comb begin
      vid_raw.hsync  = (hcount_q >= HS_START && hcount_q <= HS_END) ? HS_ON : ~HS_ON;
      vid_raw.vsync  = (vcount_q >= VS_START && vcount_q <= VS_END) ? VS_ON : ~VS_ON;
      vid_raw.active = (hcount_q < H_ACT) && (vcount_q < V_ACT);
   end

   if (SYNC_DELAY == 0) begin : g_no_delay
      // Reset must still force idle levels even though this path has no flops.
      assign vid_out = reset_n ? vid_raw : VID_IDLE;
   end else begin : g_delay
      vid_t pipe_q [SYNC_DELAY];
      vid_t pipe_d [SYNC_DELAY];

      always_comb begin
         pipe_d = pipe_q;
         if (pix_en) begin
            pipe_d[0] = vid_raw;
            for (int i = 1; i < SYNC_DELAY; i++) begin
               pipe_d[i] = pipe_q[i-1];
            end
         end
      end

      // NOTE: every stage is reset, not just the last one, so no stale sync level ever leaks out.
      always_ff @(posedge vga_clock or negedge reset_n) begin
         if (!reset_n) begin
            for (int i = 0; i < SYNC_DELAY; i++) begin
               pipe_q[i] <= VID_IDLE;
            end
         end else begin
            pipe_q <= pipe_d;
         end
      end

      assign vid_out = pipe_q[SYNC_DELAY-1];
   end

   assign hcount          = hcount_q;
   assign vcount          = vcount_q;
   assign frame_count     = frame_count_q;
   assign hsync           = vid_out.hsync;
   assign vsync           = vid_out.vsync;
   assign at_display_area = vid_out.active;
   assign blank           = ~vid_out.active;
   assign start_of_frame  = reset_n && pix_en && (hcount_q == '0) && (vcount_q == '0);
   assign end_of_line     = reset_n && pix_en && (hcount_q == H_ACT_LAST);

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three modes share clock, reset and pix_en; each is compared every clock
// against a model that derives all outputs from the enabled-pixel count since reset.
module tb_vga_timing_gen;

   typedef struct packed {
      int ha; int hfp; int hs; int hbp;
      int va; int vfp; int vs; int vbp;
      int hpol; int vpol; int fw; int d;
   } mode_t;

   localparam mode_t M_DEF = '{640, 16, 96, 48, 480, 10, 2, 33, 0, 0, 8, 2};
   localparam mode_t M_MID = '{16, 2, 4, 3, 10, 1, 2, 2, 1, 0, 3, 3};
   localparam mode_t M_SML = '{8, 1, 2, 1, 4, 1, 1, 1, 1, 1, 2, 0};

   logic clk = 1'b0;
   logic reset_n;
   logic pix_en;

   logic [10:0] def_hc, def_vc;
   logic [7:0]  def_fc;
   logic        def_hs, def_vs, def_ad, def_bl, def_sof, def_eol;
   logic [4:0]  mid_hc, mid_vc;
   logic [2:0]  mid_fc;
   logic        mid_hs, mid_vs, mid_ad, mid_bl, mid_sof, mid_eol;
   logic [3:0]  sml_hc, sml_vc;
   logic [1:0]  sml_fc;
   logic        sml_hs, sml_vs, sml_ad, sml_bl, sml_sof, sml_eol;

   longint p;       // enabled clock edges since reset release
   int     cyc;
   int     errors;
   int     checks;

   always #5 clk = ~clk;

   vga_timing_gen u_def (
      .vga_clock(clk), .reset_n(reset_n), .pix_en(pix_en),
      .hcount(def_hc), .vcount(def_vc), .hsync(def_hs), .vsync(def_vs),
      .at_display_area(def_ad), .blank(def_bl), .start_of_frame(def_sof),
      .end_of_line(def_eol), .frame_count(def_fc)
   );

   vga_timing_gen #(
      .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
      .V_ACTIVE(10), .V_FP(1), .V_SYNC(2), .V_BP(2),
      .H_SYNC_POL(1), .V_SYNC_POL(0), .COUNT_W(5), .FRAME_W(3), .SYNC_DELAY(3)
   ) u_mid (
      .vga_clock(clk), .reset_n(reset_n), .pix_en(pix_en),
      .hcount(mid_hc), .vcount(mid_vc), .hsync(mid_hs), .vsync(mid_vs),
      .at_display_area(mid_ad), .blank(mid_bl), .start_of_frame(mid_sof),
      .end_of_line(mid_eol), .frame_count(mid_fc)
   );

   vga_timing_gen #(
      .H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
      .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
      .H_SYNC_POL(1), .V_SYNC_POL(1), .COUNT_W(4), .FRAME_W(2), .SYNC_DELAY(0)
   ) u_sml (
      .vga_clock(clk), .reset_n(reset_n), .pix_en(pix_en),
      .hcount(sml_hc), .vcount(sml_vc), .hsync(sml_hs), .vsync(sml_vs),
      .at_display_area(sml_ad), .blank(sml_bl), .start_of_frame(sml_sof),
      .end_of_line(sml_eol), .frame_count(sml_fc)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s @cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
      end
   endtask

   // Model: position is a plain function of the enabled-pixel count p; delayed outputs look at p-d.
   task automatic check_mode(input string name, input mode_t m,
                             input logic [31:0] hc, input logic [31:0] vc, input logic [31:0] fc,
                             input logic hs, input logic vs, input logic ad, input logic bl,
                             input logic sof, input logic eol);
      longint ht, vt, q, hq, vq;
      logic [31:0] eh, ev, ef;
      logic ehs, evs, ead, esof, eeol;
      ht = m.ha + m.hfp + m.hs + m.hbp;
      vt = m.va + m.vfp + m.vs + m.vbp;
      q  = p - m.d;
      if (!reset_n) begin
         eh = 0; ev = 0; ef = 0; esof = 1'b0; eeol = 1'b0;
      end else begin
         eh   = 32'(p % ht);
         ev   = 32'((p / ht) % vt);
         ef   = 32'((p / (ht * vt)) % (64'd1 << m.fw));
         esof = pix_en && eh == 0 && ev == 0;
         eeol = pix_en && eh == 32'(m.ha - 1);
      end
      if (!reset_n || q < 0) begin
         ehs = ~m.hpol[0];
         evs = ~m.vpol[0];
         ead = 1'b0;
      end else begin
         hq  = q % ht;
         vq  = (q / ht) % vt;
         ehs = (hq >= m.ha + m.hfp && hq < m.ha + m.hfp + m.hs) ? m.hpol[0] : ~m.hpol[0];
         evs = (vq >= m.va + m.vfp && vq < m.va + m.vfp + m.vs) ? m.vpol[0] : ~m.vpol[0];
         ead = (hq < m.ha) && (vq < m.va);
      end
      check({name, ".hcount"}, hc, eh);
      check({name, ".vcount"}, vc, ev);
      check({name, ".frame_count"}, fc, ef);
      check({name, ".hsync"}, 32'(hs), 32'(ehs));
      check({name, ".vsync"}, 32'(vs), 32'(evs));
      check({name, ".at_display_area"}, 32'(ad), 32'(ead));
      check({name, ".blank"}, 32'(bl), 32'(!ead));
      check({name, ".start_of_frame"}, 32'(sof), 32'(esof));
      check({name, ".end_of_line"}, 32'(eol), 32'(eeol));
   endtask

   task automatic check_all();
      check_mode("def", M_DEF, 32'(def_hc), 32'(def_vc), 32'(def_fc),
                 def_hs, def_vs, def_ad, def_bl, def_sof, def_eol);
      check_mode("mid", M_MID, 32'(mid_hc), 32'(mid_vc), 32'(mid_fc),
                 mid_hs, mid_vs, mid_ad, mid_bl, mid_sof, mid_eol);
      check_mode("sml", M_SML, 32'(sml_hc), 32'(sml_vc), 32'(sml_fc),
                 sml_hs, sml_vs, sml_ad, sml_bl, sml_sof, sml_eol);
   endtask

   // Drive on the falling edge, compare just after, and advance the model for the coming rising edge.
   task automatic step(input logic en, input logic rn);
      @(negedge clk);
      pix_en  = en;
      reset_n = rn;
      #1;
      check_all();
      if (en && rn) p++;
      cyc++;
   endtask

   initial begin
      reset_n = 1'b0;
      pix_en  = 1'b0;
      p       = 0;
      cyc     = 0;
      errors  = 0;
      checks  = 0;

      repeat (3) step(1'b1, 1'b0);
      repeat (900) step(1'b1, 1'b1);
      for (int i = 0; i < 1000; i++) step(i % 2 == 0, 1'b1);
      repeat (5000) step($urandom_range(0, 3) != 0, 1'b1);

      // Asynchronous reset between edges, in the middle of a frame for every mode.
      @(negedge clk);
      #2 reset_n = 1'b0;
      #1 p = 0;
      check_all();
      repeat (2) step($urandom_range(0, 1) != 0, 1'b0);
      step(1'b1, 1'b1);
      repeat (3000) step($urandom_range(0, 3) != 0, 1'b1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
